// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, frame constants and
// the baud_select rate table with its 16x oversampling divisor helper.
package uart_receiver_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned TICK_W     = 4;
  localparam int unsigned BITCNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Clocks per sample tick, rounded to nearest and never below one.
  function automatic int unsigned baud_divisor(input int unsigned clk_freq, input logic [2:0] sel);
    int unsigned step;
    int unsigned div;
    step = baud_rate(sel) * OVERSAMPLE;
    div  = (clk_freq + step / 2) / step;
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Generates sample_ENABLE, a one-clock pulse at 16x the selected baud rate.
module baud_controller
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       reset,
  input  logic       clk,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);

  // The slowest rate has the largest divisor and sets the counter width.
  localparam int unsigned CNT_W = $clog2(baud_divisor(CLK_FREQ, 3'd0) + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_last;
  logic             en_q, en_d;

  always_comb begin
    case (baud_select)
      3'd0:    div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd0) - 32'd1);
      3'd1:    div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd1) - 32'd1);
      3'd2:    div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd2) - 32'd1);
      3'd3:    div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd3) - 32'd1);
      3'd4:    div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd4) - 32'd1);
      3'd5:    div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd5) - 32'd1);
      3'd6:    div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd6) - 32'd1);
      default: div_last = CNT_W'(baud_divisor(CLK_FREQ, 3'd7) - 32'd1);
    endcase
  end

  // >= lets the counter recover at once when baud_select shrinks the divisor.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    en_d  = 1'b0;
    if (cnt_q >= div_last) begin
      cnt_d = '0;
      en_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign sample_ENABLE = en_q;

endmodule

// File: rtl/uart_receiver.sv
// 8E1 UART receiver: 2-flop synchronized RxD, 16x oversampling, mid-bit sampling
// at tick 7, with registered data, valid pulse and sticky parity/framing flags.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  logic sample_en;
  logic start_fall;
  logic mid_bit;

  baud_controller #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud (
    .reset         (reset),
    .clk           (clk),
    .baud_select   (baud_select),
    .sample_ENABLE (sample_en)
  );

  assign start_fall = rx_prev_q & ~rx_sync_q;
  assign mid_bit    = sample_en && (tick_q == TICK_W'(MID_TICK));

  // State and datapath registers; synchronizer idles at the line's mark level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic; dropping Rx_EN abandons any frame immediately.
  always_comb begin
    state_d = state_q;
    if (!Rx_EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_fall) state_d = ST_START;
        ST_START:  if (mid_bit) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        ST_DATA:   if (mid_bit && (bit_cnt_q == BITCNT_W'(DATA_BITS - 1))) state_d = ST_PARITY;
        ST_PARITY: if (mid_bit) state_d = ST_STOP;
        ST_STOP:   if (mid_bit) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and outputs; nothing but the free-running tick moves while disabled.
  always_comb begin
    tick_d    = sample_en ? tick_q + TICK_W'(1) : tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    if (Rx_EN) begin
      case (state_q)
        ST_IDLE: begin
          if (start_fall) tick_d = '0;
        end
        ST_START: begin
          if (mid_bit && !rx_sync_q) begin
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          if (mid_bit) begin
            shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (mid_bit) par_err_d = ^{shift_q, rx_sync_q};
        end
        ST_STOP: begin
          if (mid_bit) begin
            data_d  = shift_q;
            ferr_d  = ~rx_sync_q;
            perr_d  = par_err_q;
            valid_d = rx_sync_q & ~par_err_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a frame table plus hand-written sequences for
// glitch rejection, back-to-back frames, enable drop and mid-frame reset.
module tb_uart_receiver;

  // 1.8432 MHz gives exact divisors: 12 at 9600, 3 at 38400, 1 at 115200.
  localparam int unsigned CLK_FREQ = 1843200;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         valid_cnt = 0;
  logic [7:0] cap[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [2:0] sel;
    int         exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  uart_receiver #(
    .CLK_FREQ (CLK_FREQ)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .RxD         (RxD),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Rx_VALID) begin
      valid_cnt++;
      cap.push_back(Rx_DATA);
    end
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: cycle budget exhausted before summary");
    $fatal(1, "watchdog");
  end

  function automatic int bit_clks(input logic [2:0] sel);
    case (sel)
      3'd5:    return 48;
      3'd7:    return 16;
      default: return 192;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int n);
    RxD = b;
    idle(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int n);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(d[i], n);
    send_bit(p, n);
    send_bit(s, n);
    RxD = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int idx);
    if (cap.size() > idx) return 32'(cap[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    //            data   par   stop  sel   valid data   perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 3'd3, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b1, 3'd3, 0, 8'h07, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 3'd3, 0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 3'd3, 1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'hE8, 1'b0, 1'b1, 3'd5, 1, 8'hE8, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 3'd7, 1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 3'd7, 0, 8'h80, 1'b1, 1'b1};

    reset = 1'b1;
    RxD = 1'b1;
    Rx_EN = 1'b1;
    baud_select = 3'd3;
    idle(5);
    reset = 1'b0;
    idle(5);
    check("reset data", 32'(Rx_DATA), 32'h00);
    check("reset valid", 32'(Rx_VALID), 32'h0);
    check("reset perr", 32'(Rx_PERROR), 32'h0);
    check("reset ferr", 32'(Rx_FERROR), 32'h0);

    for (int i = 0; i < 7; i++) begin
      baud_select = vecs[i].sel;
      idle(2 * bit_clks(vecs[i].sel));
      valid_cnt = 0;
      cap.delete();
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, bit_clks(vecs[i].sel));
      idle(2 * bit_clks(vecs[i].sel));
      check($sformatf("vec%0d valid_count", i), 32'(valid_cnt), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d data", i), 32'(Rx_DATA), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d perr", i), 32'(Rx_PERROR), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d ferr", i), 32'(Rx_FERROR), 32'(vecs[i].exp_ferr));
    end

    // 4-tick low glitch must leave data and sticky flags untouched.
    baud_select = 3'd3;
    idle(2 * 192);
    valid_cnt = 0;
    RxD = 1'b0;
    idle(4 * 12);
    RxD = 1'b1;
    idle(3 * 192);
    check("glitch valid_count", 32'(valid_cnt), 32'h0);
    check("glitch data", 32'(Rx_DATA), 32'h80);
    check("glitch perr", 32'(Rx_PERROR), 32'h1);
    check("glitch ferr", 32'(Rx_FERROR), 32'h1);

    // Back-to-back frames at 115200.
    baud_select = 3'd7;
    idle(32);
    valid_cnt = 0;
    cap.delete();
    send_frame(8'h81, 1'b0, 1'b1, 16);
    send_frame(8'h7E, 1'b0, 1'b1, 16);
    idle(32);
    check("b2b valid_count", 32'(valid_cnt), 32'd2);
    check("b2b first", cap_at(0), 32'h81);
    check("b2b second", cap_at(1), 32'h7E);
    check("b2b perr", 32'(Rx_PERROR), 32'h0);
    check("b2b ferr", 32'(Rx_FERROR), 32'h0);

    // Rx_EN falls during data bits; the frame is dropped silently.
    baud_select = 3'd3;
    idle(2 * 192);
    valid_cnt = 0;
    fork
      send_frame(8'h12, 1'b0, 1'b1, 192);
      begin
        idle(3 * 192);
        Rx_EN = 1'b0;
      end
    join
    idle(192);
    Rx_EN = 1'b1;
    idle(2 * 192);
    check("en_drop valid_count", 32'(valid_cnt), 32'h0);
    check("en_drop data", 32'(Rx_DATA), 32'h7E);
    check("en_drop perr", 32'(Rx_PERROR), 32'h0);
    check("en_drop ferr", 32'(Rx_FERROR), 32'h0);

    // Reset in the middle of data bit 4, then a clean 0xC3.
    valid_cnt = 0;
    send_bit(1'b0, 192);
    send_bit(1'b0, 192);
    send_bit(1'b1, 192);
    send_bit(1'b0, 192);
    send_bit(1'b1, 192);
    RxD = 1'b1;
    idle(96);
    reset = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(2);
    check("midreset data", 32'(Rx_DATA), 32'h00);
    check("midreset perr", 32'(Rx_PERROR), 32'h0);
    check("midreset ferr", 32'(Rx_FERROR), 32'h0);
    check("midreset valid_count", 32'(valid_cnt), 32'h0);
    idle(2 * 192);
    valid_cnt = 0;
    cap.delete();
    send_frame(8'hC3, 1'b0, 1'b1, 192);
    idle(2 * 192);
    check("post_reset valid_count", 32'(valid_cnt), 32'd1);
    check("post_reset captured", cap_at(0), 32'hC3);
    check("post_reset data", 32'(Rx_DATA), 32'hC3);
    check("post_reset perr", 32'(Rx_PERROR), 32'h0);
    check("post_reset ferr", 32'(Rx_FERROR), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz; SHALL be forwarded to the baud generator.
REQ-002 Port clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port baud_select  input  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
REQ-005 Port Rx_EN  input  1  receiver enable; when low, the block SHALL stay in IDLE.
REQ-006 Port RxD  input  1  asynchronous serial line; idles high.
REQ-007 Port Rx_DATA  output  8  last received byte.
REQ-008 Port Rx_VALID  output  1  one-clk pulse: frame accepted with no errors.
REQ-009 Port Rx_PERROR  output  1  parity error flag.
REQ-010 Port Rx_FERROR  output  1  framing error flag.

Function
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
REQ-012 RxD SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-013 Timing SHALL come from sample_ENABLE, a one-clk pulse at 16x baud rate (divisor = round(CLK_FREQ/(16*baud))).
REQ-014 A 4-bit tick counter SHALL increment only on sample_ENABLE; it SHALL wrap 15->0 and SHALL clear on start detection.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START on a synchronized 1->0 transition of RxD while Rx_EN=1.
REQ-017 In START, at tick 7 (mid-bit): RxD=0 -> DATA; RxD=1 -> IDLE (glitch rejected, no flags changed).
REQ-018 In DATA, RxD SHALL be sampled at tick 7 of each bit into a shift register; after the 8th bit -> PARITY.
REQ-019 In PARITY, at tick 7, the parity bit SHALL be sampled; the error condition is XOR of the 8 data bits and the parity bit = 1; then -> STOP.
REQ-020 In STOP, at tick 7: Rx_DATA SHALL load the shift register; Rx_FERROR SHALL be set if RxD=0; Rx_PERROR SHALL be set per REQ-019; Rx_VALID SHALL pulse one clk only if both errors are clear; then -> IDLE.
REQ-021 Latency: Rx_VALID SHALL assert within 2 clk of the stop-bit tick 7.
REQ-022 Rx_PERROR and Rx_FERROR SHALL hold until the next accepted start bit (REQ-017 DATA transition), then clear.
REQ-023 Rx_DATA SHALL hold its value until the next STOP completes, including for errored frames.
REQ-024 If Rx_EN falls mid-frame, the FSM SHALL return to IDLE on the next clk with no flag or data change.
REQ-025 A falling edge in STOP after tick 7 SHALL be honoured as the next start bit (back-to-back frames).
REQ-026 baud_select changes mid-frame give an undefined result for that frame; the next frame SHALL be correct.

Reset
REQ-027 On reset: state=IDLE, tick counter=0, shift register=0, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abandon the frame with no Rx_VALID pulse.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding, the baud_select rate table, and the frame constants (DATA_BITS=8, OVERSAMPLE=16, MID_TICK=7).
REQ-030 The existing baud_controller (reset, clk, baud_select -> sample_ENABLE) SHALL be instantiated as the only sub-module.

Verification
REQ-031 CLK_FREQ=50 MHz, baud_select=011, Rx_EN=1, send 0xA5 with parity 0 and stop 1 -> Rx_DATA=8'hA5, one Rx_VALID pulse, both error flags 0.
REQ-032 Send 0x07 with parity 0 (correct value is 1) -> Rx_PERROR=1, Rx_VALID never asserts, Rx_DATA=8'h07.
REQ-033 Send 0x3C with stop bit 0 -> Rx_FERROR=1, no Rx_VALID; the next good frame 0x55 clears the flags -> Rx_VALID, Rx_DATA=8'h55.
REQ-034 Send a 4-tick low glitch on idle RxD -> state returns to IDLE; no output changes.
REQ-035 Send 0x81 and 0x7E back-to-back at baud_select=111 -> two Rx_VALID pulses, with data 8'h81 then 8'h7E.
REQ-036 Assert reset during DATA bit 4 of a frame, then send 0xC3 -> outputs reset to zero, then one Rx_VALID with 8'hC3.
